// File: rtl/ddr_xfer_seq.sv
// Splits a DDR transfer request into beat-aligned chunks that never cross a
// MAX_CHUNK boundary, and issues them one at a time to an AXI data mover.
module ddr_xfer_seq #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned LEN_WIDTH  = 24,
  parameter int unsigned BEAT_BYTES = 32,
  parameter int unsigned MAX_CHUNK  = 4096,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_cmptd,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_bytes,
  input  logic                  req_write,
  output logic                  ddr_conf,
  output logic [ADDR_WIDTH-1:0] ddr_st_addr_out,
  output logic [LEN_WIDTH-1:0]  ddr_len,
  output logic                  cmd_type,
  output logic [2:0]            axi_size,
  input  logic                  mover_idle,
  output logic                  done,
  output logic                  err,
  output logic                  busy,
  output logic [15:0]           chunk_cnt
);

  localparam int unsigned BEAT_SH = $clog2(BEAT_BYTES);
  localparam int unsigned OFF_W   = $clog2(MAX_CHUNK);
  localparam int unsigned CHUNK_W = OFF_W + 1;
  localparam int unsigned REM_W   = 33;
  localparam int unsigned TO_W    = $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CALC   = 3'd1,
    ISSUE  = 3'd2,
    GUARD  = 3'd3,
    WAIT   = 3'd4,
    FINISH = 3'd5
  } state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] addr;
  logic [REM_W-1:0]      remaining;
  logic [CHUNK_W-1:0]    chunk;
  logic                  dir;
  logic [TO_W-1:0]       cnt;

  logic                  clear_c;
  logic                  accept_c;
  logic [REM_W-1:0]      rem_round_c;
  logic [CHUNK_W-1:0]    to_bound_c;
  logic [CHUNK_W-1:0]    chunk_c;

  assign clear_c   = !rst_n || !init_cmptd;
  assign req_ready = (state == IDLE) && mover_idle;
  assign accept_c  = req_valid && req_ready;
  assign axi_size  = 3'(BEAT_SH);

  // 33-bit rounding so a length near 4 GiB rounds up without wrapping
  assign rem_round_c = (REM_W'(req_bytes) + REM_W'(BEAT_BYTES - 1))
                       & ~REM_W'(BEAT_BYTES - 1);

  // Distance to the next MAX_CHUNK boundary caps the chunk length
  assign to_bound_c = CHUNK_W'(MAX_CHUNK) - CHUNK_W'(addr[OFF_W-1:0]);
  assign chunk_c    = (remaining < REM_W'(to_bound_c)) ? CHUNK_W'(remaining)
                                                       : to_bound_c;

  always_ff @(posedge clk) begin
    if (clear_c) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (accept_c) state_next = CALC;
      CALC:   state_next = (remaining == '0) ? FINISH : ISSUE;
      ISSUE:  state_next = GUARD;
      // Mover idle lags conf by a registered stage, so it is not trusted here
      GUARD:  if (cnt == TO_W'(1)) state_next = WAIT;
      WAIT: begin
        if (mover_idle)                       state_next = CALC;
        else if (cnt == TO_W'(TIMEOUT - 1))   state_next = FINISH;
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (clear_c) begin
      addr            <= '0;
      remaining       <= '0;
      chunk           <= '0;
      dir             <= 1'b0;
      cnt             <= '0;
      ddr_conf        <= 1'b0;
      ddr_st_addr_out <= '0;
      ddr_len         <= '0;
      cmd_type        <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      busy            <= 1'b0;
      chunk_cnt       <= '0;
    end else begin
      cnt      <= (state_next != state) ? '0 : cnt + TO_W'(1);
      busy     <= (state_next != IDLE);
      ddr_conf <= (state_next == ISSUE);
      done     <= (state_next == FINISH);

      case (state)
        IDLE: begin
          if (accept_c) begin
            addr      <= req_addr & ~ADDR_WIDTH'(BEAT_BYTES - 1);
            remaining <= rem_round_c;
            dir       <= req_write;
            chunk_cnt <= '0;
            err       <= 1'b0;
          end
        end
        CALC: begin
          if (state_next == ISSUE) begin
            chunk           <= chunk_c;
            ddr_st_addr_out <= addr;
            ddr_len         <= LEN_WIDTH'(chunk_c);
            cmd_type        <= dir;
          end
        end
        ISSUE: begin
          addr      <= addr + ADDR_WIDTH'(chunk);
          remaining <= remaining - REM_W'(chunk);
          if (chunk_cnt != {CNT_W{1'b1}}) chunk_cnt <= chunk_cnt + CNT_W'(1);
        end
        WAIT: begin
          if (state_next == FINISH) err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
